// File: rtl/uart_pkg.sv
// Shared uart-side definitions: default byte width and the transmit-side handshake FSM encoding.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_RDY} tx_fsm_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers for full/empty, registered read data and synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    lvl
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_dat_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_dat_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (rd_en) rd_dat_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

  assign rd_dat = rd_dat_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign lvl    = LW'(wr_ptr_q - rd_ptr_q);
endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the uart transmitter; issues one txv strobe per byte and waits out a full cts cycle.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = 16,
  parameter int LW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_dat,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic                 flush,
  output logic [DATA_BITS-1:0] txd,
  output logic                 txv,
  input  logic                 cts,
  output logic [LW-1:0]        lvl,
  output logic                 busy
);
  tx_fsm_t state_q, state_d;
  logic    empty, full, wr_en, pop;

  assign in_rdy = !full && !flush;
  assign wr_en  = in_val && in_rdy;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .wr_en  (wr_en),
    .wr_dat (in_dat),
    .rd_en  (pop),
    .rd_dat (txd),
    .full   (full),
    .empty  (empty),
    .lvl    (lvl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty && cts && !flush) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!cts) state_d = WAIT_RDY;
      WAIT_RDY:  if (cts) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // txv decodes straight from the state register so an async reset kills it mid-strobe.
  always_comb begin
    pop  = (state_q == IDLE) && !empty && cts && !flush;
    txv  = (state_q == ISSUE);
    busy = (state_q != IDLE) || !empty;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: queue-based reference model, loopback uart responder and literal checks.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_dat = '0;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic          flush = 1'b0;
  logic [7:0]    txd;
  logic          txv;
  logic          cts;
  logic [LW-1:0] lvl;
  logic          busy;

  logic cts_uart = 1'b1;
  logic cts_en   = 1'b1;
  assign cts = cts_uart && cts_en;

  uart_tx_feeder #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_val(in_val), .in_rdy(in_rdy),
    .flush(flush), .txd(txd), .txv(txv), .cts(cts), .lvl(lvl), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Loopback uart: takes txv while cts=1, goes busy for a frame, then returns to idle.
  logic [7:0] rx_q[$];
  int         rx_edge   = 0;
  int         frame_len = 3;
  bit         frame_rnd = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && txv && cts) begin
        rx_q.push_back(txd);
        rx_edge = cyc + 1;
        @(posedge clk); #2 cts_uart = 1'b0;
        repeat (frame_rnd ? $urandom_range(1, 4) : frame_len) @(posedge clk);
        #2 cts_uart = 1'b1;
      end
    end
  end

  // Reference model: a byte queue plus the one-in-flight rule (strobe, then a full cts low/high cycle).
  logic [7:0] mq[$];
  logic [7:0] m_txd;
  bit m_strobe, m_inflight, m_low, m_pop, m_wr, o_strobe, o_low;
  initial begin
    m_txd = '0; m_strobe = 0; m_inflight = 0; m_low = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete(); m_txd = '0; m_strobe = 0; m_inflight = 0; m_low = 0;
      end else begin
        o_strobe = m_strobe;
        o_low    = m_low;
        m_pop = !m_inflight && (mq.size() > 0) && cts && !flush;
        m_wr  = in_val && (mq.size() < DEPTH) && !flush;
        if (m_inflight && !o_strobe) begin
          if (!o_low && !cts)     m_low = 1;
          else if (o_low && cts)  m_inflight = 0;
        end
        m_strobe = 0;
        if (flush) mq.delete();
        if (m_pop) begin
          m_txd = mq.pop_front();
          m_strobe = 1; m_inflight = 1; m_low = 0;
        end
        if (m_wr) mq.push_back(in_dat);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("txv",    txv,    m_strobe);
        chk("txd",    txd,    m_txd);
        chk("lvl",    lvl,    mq.size());
        chk("busy",   busy,   m_inflight || (mq.size() > 0));
        chk("in_rdy", in_rdy, (mq.size() < DEPTH) && !flush);
        chk("lvl_max", lvl <= DEPTH, 1);
      end
    end
  end

  int wr_edge = 0;
  task automatic push(input logic [7:0] b);
    in_dat = b; in_val = 1'b1;
    @(posedge clk); #2 in_val = 1'b0;
    wr_edge = cyc;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin @(posedge clk); k++; end
    #2;
    chk({name, "_rx_count"}, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    chk({name, "_idle"}, busy, 0);
    @(posedge clk); #2;
  endtask

  task automatic wait_txv(input int budget, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!txv && k < budget);
    chk({name, "_txv_seen"}, txv, 1);
  endtask

  int errs;
  int sent;
  bit acc;

  initial begin
    // Reset state
    #12;
    chk("rst_lvl", lvl, 0);
    chk("rst_txv", txv, 0);
    chk("rst_txd", txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_rdy", in_rdy, 1);
    @(posedge clk); #2 rst = 1'b0;

    // Single byte through loopback
    push(8'hA5);
    @(negedge clk);
    chk("single_lvl1", lvl, 1);
    chk("single_txv0", txv, 0);
    @(negedge clk);
    chk("single_lvl0", lvl, 0);
    chk("single_txv1", txv, 1);
    chk("single_txd", txd, 8'hA5);
    wait_idle(50, "single");
    chk("single_rx", rx_q[0], 8'hA5);
    chk("single_latency", rx_edge - wr_edge, 2);

    // Burst to full with cts held low
    rx_q.delete();
    cts_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(i[7:0]);
    @(negedge clk);
    chk("burst_lvl_full", lvl, 16);
    chk("burst_in_rdy0", in_rdy, 0);
    @(posedge clk); #2;
    push(8'h99);
    @(negedge clk);
    chk("burst_17th_dropped", lvl, 16);
    @(posedge clk); #2 cts_en = 1'b1;
    wait_rx(16, 600, "burst");
    errs = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != i[7:0]) errs++;
    chk("burst_order_errs", errs, 0);
    wait_idle(50, "burst");

    // Wrap-around stream with random gaps and frame lengths
    rx_q.delete();
    frame_rnd = 1'b1;
    sent = 0;
    for (int g = 0; g < 20000 && sent < 256; g++) begin
      in_val = ($urandom_range(0, 3) != 0);
      in_dat = sent[7:0];
      #1 acc = in_val && in_rdy;
      @(posedge clk); #2;
      if (acc) sent++;
    end
    in_val = 1'b0;
    chk("wrap_sent", sent, 256);
    wait_rx(256, 4000, "wrap");
    errs = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != i[7:0]) errs++;
    chk("wrap_order_errs", errs, 0);
    frame_rnd = 1'b0;
    wait_idle(50, "wrap");

    // Write and pop in the same cycle
    rx_q.delete();
    cts_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h10 + i[7:0]);
    @(negedge clk);
    chk("simul_lvl_before", lvl, 5);
    @(posedge clk); #2;
    in_dat = 8'h15; in_val = 1'b1; cts_en = 1'b1;
    @(posedge clk); #2 in_val = 1'b0;
    @(negedge clk);
    chk("simul_lvl_after", lvl, 5);
    chk("simul_txd", txd, 8'h10);
    wait_rx(6, 200, "simul");
    errs = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != 8'h10 + i[7:0]) errs++;
    chk("simul_order_errs", errs, 0);
    wait_idle(50, "simul");

    // Flush while a byte is in flight
    rx_q.delete();
    cts_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h40 + i[7:0]);
    cts_en = 1'b1;
    wait_txv(20, "flush");
    @(posedge clk); #2;
    flush = 1'b1; in_val = 1'b1; in_dat = 8'hEE;
    @(negedge clk);
    chk("flush_lvl7", lvl, 7);
    chk("flush_busy", busy, 1);
    @(posedge clk); #2;
    flush = 1'b0; in_val = 1'b0;
    @(negedge clk);
    chk("flush_lvl0", lvl, 0);
    wait_idle(50, "flush");
    repeat (10) @(posedge clk);
    #2;
    chk("flush_rx_count", rx_q.size(), 1);
    chk("flush_rx_byte", rx_q[0], 8'h40);

    // Async reset in the middle of the strobe
    push(8'h77);
    wait_txv(10, "arst");
    #1 rst = 1'b1;
    #1;
    chk("arst_txv", txv, 0);
    chk("arst_txd", txd, 0);
    chk("arst_lvl", lvl, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rx_q.delete();
    chk("arst_in_rdy", in_rdy, 1);
    push(8'h3C);
    wait_rx(1, 50, "arst");
    chk("arst_rx_byte", rx_q[0], 8'h3C);
    wait_idle(50, "arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer directly upstream of the uart transmit port.
- Accepts bytes from a producer over a valid/ready stream and stores them in a FIFO of DEPTH entries.
- Drains the FIFO one byte at a time into the uart using its txd/txv/cts handshake.
- Lets callers burst data without tracking per-byte uart readiness.

Parameters:
- DATA_BITS, 8: byte width; must match the uart DATA_BITS.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- LW, $clog2(DEPTH+1): width of lvl (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_dat  in  DATA_BITS  producer byte.
- in_val  in  1  producer byte valid.
- in_rdy  out  1  feeder can accept; a write occurs when in_val && in_rdy.
- flush  in  1  synchronous FIFO clear.
- txd  out  DATA_BITS  byte to uart.
- txv  out  1  single-cycle transmit strobe to uart.
- cts  in  1  uart clear-to-send (idle, ready for txv).
- lvl  out  LW  current FIFO occupancy, 0..DEPTH.
- busy  out  1  high while the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release): FIFO empty, lvl=0, txd=0, txv=0, FSM=IDLE, busy=0, in_rdy=1.
- Uart contract (decided): the uart samples txv only when cts=1 and drops cts no later than the cycle after sampling txv. cts returns to 1 after the stop bit(s).
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - in_rdy = !full && !flush (combinational from registered state and flush).
  - Write and pop in the same cycle: lvl is unchanged.
  - lvl increments on write-only and decrements on pop-only.
  - Write when full is impossible because in_rdy=0; overflow logic is not required.
- FSM states:
  - IDLE: if !empty && cts && !flush, pop the head into txd and go to ISSUE.
  - ISSUE: txv=1 for exactly this cycle; txd holds the popped byte; go to WAIT_BUSY.
  - WAIT_BUSY: txv=0; stay until cts=0, then go to WAIT_RDY.
  - WAIT_RDY: stay until cts=1, then go to IDLE.
- Latency and throughput:
  - A byte written into an empty FIFO while cts=1: pop occurs on the next cycle (IDLE sees !empty), and txv asserts the cycle after that. Write-to-txv latency is 2 cycles.
  - At most one byte is in flight; the next txv requires a full cts 1->0->1 cycle.
- txd:
  - Registered; updates only on pop and holds its value between strobes.
  - Bytes leave in strict FIFO order.
- flush:
  - Clears both pointers and lvl to 0 in the next cycle; any write presented in that cycle is dropped.
  - Does not abort a byte already popped. If the FSM is in ISSUE, WAIT_BUSY or WAIT_RDY, it completes the sequence normally.
  - IDLE does not pop during flush.
- Wrap-around: pointer wrap past DEPTH-1 must preserve ordering and full/empty correctness indefinitely.
- Reset mid-operation: all state clears immediately, including txv, even mid-strobe. A uart frame already started is the uart's concern.
- busy = (FSM != IDLE) || !empty.

Decomposition:
- Shared package uart_pkg:
  - DATA_BITS default constant.
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_RDY} tx_fsm_t, shared with future rx-side stages.
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - Ports: wr_en, wr_dat, rd_en, rd_dat, full, empty, lvl, clr.
  - Read data is registered on rd_en.
- uart_tx_feeder instantiates sync_fifo and the FSM.

Test Plan:
- Loopback, single byte: reset, write 8'hA5 with cts=1 held, uart in loopback -> txv pulses once, 2 cycles after the write, with txd=8'hA5; the rx side returns 8'hA5; lvl goes 1->0; busy drops after cts re-rises.
- Burst to full: with cts=0, write 0x00..0x0F (DEPTH=16) -> lvl=16, in_rdy=0, and a 17th in_val is not accepted. Release cts -> 16 txv strobes with txd 0x00..0x0F in order, each separated by a full cts cycle.
- Wrap-around: stream 256 bytes 0x00..0xFF through the uart loopback with random in_val gaps -> all 256 received in order with no loss or duplication; lvl never exceeds 16.
- Simultaneous write/pop: lvl=5; present a write in the same cycle IDLE pops -> lvl stays 5; order is preserved.
- Flush: lvl=7 with FSM in WAIT_BUSY; assert flush for 1 cycle with in_val=1 -> lvl=0 next cycle, and the in-flight byte completes. No further txv occurs; the write presented with flush is not stored.
- Async reset mid-ISSUE: assert rst while txv=1 -> txv, txd, lvl and busy are 0 immediately, without waiting for clk; after release, in_rdy=1 and a new byte 8'h3C is sent correctly.
